// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor bit per clock, LSB first.
// Define SERIAL_SUB_SIGNED_OVF_EN to add a registered signed-overflow output.
module serial_subtractor #(
  parameter int NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                borrow_in,
  output logic [NUM_BITS-1:0] difference,
  output logic                underflow,
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  output logic                overflow,
`endif
  output logic                busy,
  output logic                done
);

  localparam int CNT_W = $clog2(NUM_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_BITS-1:0] a_sh_q, a_sh_d;
  logic [NUM_BITS-1:0] b_sh_q, b_sh_d;
  logic [NUM_BITS-1:0] res_q, res_d;
  logic                borrow_q, borrow_d;
  logic [NUM_BITS-1:0] difference_q, difference_d;
  logic                underflow_q, underflow_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic                overflow_q, overflow_d;
`endif

  logic                diff_bit;
  logic                borrow_nxt;
  logic                last_bit;
  logic                accept;
  logic [NUM_BITS-1:0] res_shifted;

  // Single-bit full subtractor on the current LSBs of the operand shifters.
  assign diff_bit    = a_sh_q[0] ^ b_sh_q[0] ^ borrow_q;
  assign borrow_nxt  = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & borrow_q);
  assign res_shifted = {diff_bit, res_q[NUM_BITS-1:1]};
  assign last_bit    = (cnt_q == CNT_W'(NUM_BITS - 1));
  assign accept      = start && (state_q != SHIFT);

  // State register plus datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      // NOTE: the shift registers are reset too, so an aborted operation leaves
      // no stale operand or partial-result bits behind.
      state_q      <= IDLE;
      cnt_q        <= '0;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_q        <= '0;
      borrow_q     <= 1'b0;
      difference_q <= '0;
      underflow_q  <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      overflow_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      res_q        <= res_d;
      borrow_q     <= borrow_d;
      difference_q <= difference_d;
      underflow_q  <= underflow_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      overflow_q   <= overflow_d;
`endif
    end
  end

  // Next-state logic.
  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; results only change on the edge finishing the MSB.
  always_comb begin
    cnt_d        = cnt_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    res_d        = res_q;
    borrow_d     = borrow_q;
    difference_d = difference_q;
    underflow_d  = underflow_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    overflow_d   = overflow_q;
`endif
    if (accept) begin
      cnt_d    = '0;
      a_sh_d   = a;
      b_sh_d   = b;
      res_d    = '0;
      borrow_d = borrow_in;
    end else if (state_q == SHIFT) begin
      cnt_d    = cnt_q + 1'b1;
      a_sh_d   = {1'b0, a_sh_q[NUM_BITS-1:1]};
      b_sh_d   = {1'b0, b_sh_q[NUM_BITS-1:1]};
      res_d    = res_shifted;
      borrow_d = borrow_nxt;
      if (last_bit) begin
        difference_d = res_shifted;
        underflow_d  = borrow_nxt;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        // On the last bit the shifter LSBs hold the original operand MSBs.
        overflow_d   = (a_sh_q[0] != b_sh_q[0]) && (diff_bit != a_sh_q[0]);
`endif
      end
    end
  end

  // Outputs.
  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
  end

  assign difference = difference_q;
  assign underflow  = underflow_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  assign overflow   = overflow_q;
`endif

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter: NUM_BITS, 8, operand/difference width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port: n_rst  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port: start  input  1  request; operands are captured when start=1 and the block is not busy.
REQ-005 SHALL have port: a  input  NUM_BITS  minuend (unsigned).
REQ-006 SHALL have port: b  input  NUM_BITS  subtrahend (unsigned).
REQ-007 SHALL have port: borrow_in  input  1  incoming borrow, subtracted at the LSB.
REQ-008 SHALL have port: difference  output  NUM_BITS  registered result a - b - borrow_in, modulo 2^NUM_BITS.
REQ-009 SHALL have port: underflow  output  1  registered final borrow-out (1 when a < b + borrow_in).
REQ-010 SHALL have port: busy  output  1  high while a subtraction is in progress.
REQ-011 SHALL have port: done  output  1  one-cycle pulse marking that difference and underflow are valid.

Function
REQ-012 SHALL implement an FSM with states IDLE, SHIFT and DONE, one bit processed per clock (LSB first), using a single-bit full-subtractor and a borrow flop.
REQ-013 SHALL, in IDLE or DONE with start=1, on that edge:
  - capture a, b and borrow_in into internal shift registers;
  - clear the bit counter;
  - enter SHIFT.
REQ-014 SHALL, in SHIFT, per edge:
  - diff_bit = a_i ^ b_i ^ borrow;
  - borrow_next = (~a_i & b_i) | (~(a_i ^ b_i) & borrow);
  - shift diff_bit into the result MSB side;
  - increment the counter.
REQ-015 SHALL leave SHIFT for DONE on the edge that processes bit NUM_BITS-1, loading difference and underflow on that same edge.
REQ-016 SHALL have a latency of exactly NUM_BITS edges: done=1 during the cycle following the NUM_BITS-th edge after the accepting edge (8 cycles at default).
REQ-017 SHALL assert done for exactly one cycle in DONE; with start=0 the FSM returns to IDLE on the next edge.
REQ-018 SHALL accept start in DONE (back-to-back operation), so a new operation begins with no idle cycle.
REQ-019 SHALL drive busy=1 in SHIFT only; busy=0 in IDLE and DONE.
REQ-020 SHALL ignore start while busy=1; a, b and borrow_in changes during SHIFT SHALL NOT affect the result.
REQ-021 SHALL hold difference and underflow stable from DONE until the end of the next completed operation; they are not updated mid-operation.
REQ-022 SHALL produce a result bit-identical to the combinational (a - b - borrow_in) for all NUM_BITS-bit inputs, including wrap-around cases (e.g. 0 - 1 = all ones, underflow=1).

Reset
REQ-023 SHALL, on a clock edge with n_rst=0:
  - enter IDLE;
  - clear difference, underflow, busy, done, the counter, the borrow flop and the shift registers.
REQ-024 SHALL abort an in-progress SHIFT on reset with no done pulse; difference is 0 on the following cycle.
REQ-025 SHALL give reset priority over start arriving on the same edge.

Configuration
REQ-026 SHALL support the macro SERIAL_SUB_SIGNED_OVF_EN.
  - When defined: the block adds output port overflow (1 bit, registered, reset 0, loaded with difference), equal to (a[MSB] != b[MSB]) && (difference[MSB] != a[MSB]), with borrow_in included in difference.
  - When undefined: the port and its logic are absent, and all other behaviour is identical.

Verification
REQ-027 SHALL cover: reset then start with a=8'h05, b=8'h03, borrow_in=0 -> busy high 8 cycles, then done pulse; difference=8'h02, underflow=0.
REQ-028 SHALL cover: a=8'h00, b=8'h01, borrow_in=0 -> difference=8'hFF, underflow=1; with the macro, overflow=0.
REQ-029 SHALL cover: a=8'hFF, b=8'hFF, borrow_in=1 -> difference=8'hFF, underflow=1; then start held in DONE with a=8'h10, b=8'h01 -> second done exactly 8 cycles later, difference=8'h0F, underflow=0.
REQ-030 SHALL cover: start with a=8'h80, b=8'h01 (macro defined) -> difference=8'h7F, underflow=0, overflow=1.
REQ-031 SHALL cover: start=1 pulsed again mid-SHIFT with different operands -> ignored; the first result is unaltered.
REQ-032 SHALL cover: n_rst=0 at SHIFT cycle 4 -> next cycle IDLE, all outputs 0, no done pulse; an exhaustive 2^17 sweep against the combinational reference reports zero mismatches.
